// File: rtl/rr_response_router.sv
// Return path of the round-robin PLM scheduler: delays each read grant tag by the PLM
// read latency, then steers the matching plm_rdata word into a per-consumer response FIFO.
module rr_response_router #(
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 2,
    parameter int NBANKS      = 1,
    parameter int NPORTS      = 1,
    parameter int PLM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    localparam int CID_W      = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1,
    localparam int NKERNELS   = NBANKS * NPORTS
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NKERNELS-1:0]                      grant_valid_i,
    input  logic [NKERNELS-1:0]                      grant_is_read_i,
    input  logic [NKERNELS-1:0][CID_W-1:0]           grant_consumer_i,
    input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]     plm_rdata_i,
    output logic [NCONSUMERS-1:0]                    resp_valid_o,
    output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]   resp_data_o,
    input  logic [NCONSUMERS-1:0]                    resp_ready_i,
    output logic [NCONSUMERS-1:0]                    overflow_o,
    output logic                                     conflict_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CID_W:0]   NCONS_C = (CID_W + 1)'(NCONSUMERS);

    logic [NKERNELS-1:0]                              tag_vld_in_s;
    logic [PLM_LATENCY-1:0][NKERNELS-1:0]             tag_vld_q;
    logic [PLM_LATENCY-1:0][NKERNELS-1:0][CID_W-1:0]  tag_cid_q;

    logic                                   steer_hit_s;
    logic                                   conflict_hit_s;
    logic [NCONSUMERS-1:0]                  push_s;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] push_data_s;
    logic [NCONSUMERS-1:0]                  pop_s;
    logic [NCONSUMERS-1:0]                  full_s;
    logic [NCONSUMERS-1:0]                  accept_s;
    logic [NCONSUMERS-1:0]                  drop_s;

    logic [VALUE_WIDTH-1:0]                 mem_q [NCONSUMERS][FIFO_DEPTH];
    logic [NCONSUMERS-1:0][PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [NCONSUMERS-1:0][PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [NCONSUMERS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NCONSUMERS-1:0]                  overflow_q, overflow_d;
    logic                                   conflict_q, conflict_d;

    // Only in-range read grants enter the pipeline; everything else becomes an empty tag.
    always_comb begin
        tag_vld_in_s = '0;
        for (int k = 0; k < NKERNELS; k++) begin
            tag_vld_in_s[k] = grant_valid_i[k] & grant_is_read_i[k]
                            & ({1'b0, grant_consumer_i[k]} < NCONS_C);
        end
    end

    // Tag delay line, never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_q <= '0;
            tag_cid_q <= '0;
        end else begin
            tag_vld_q[0] <= tag_vld_in_s;
            tag_cid_q[0] <= grant_consumer_i;
            for (int s = 1; s < PLM_LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_cid_q[s] <= tag_cid_q[s-1];
            end
        end
    end

    // Steering: lowest kernel wins a consumer, any further hit on it is a conflict.
    always_comb begin
        push_s         = '0;
        push_data_s    = '0;
        conflict_hit_s = 1'b0;
        steer_hit_s    = 1'b0;
        for (int c = 0; c < NCONSUMERS; c++) begin
            for (int k = 0; k < NKERNELS; k++) begin
                steer_hit_s = tag_vld_q[PLM_LATENCY-1][k]
                            && (tag_cid_q[PLM_LATENCY-1][k] == CID_W'(c));
                if (steer_hit_s && !push_s[c]) begin
                    push_s[c]      = 1'b1;
                    push_data_s[c] = plm_rdata_i[k];
                end else if (steer_hit_s) begin
                    conflict_hit_s = 1'b1;
                end else begin
                    conflict_hit_s = conflict_hit_s;
                end
            end
        end
    end

    // FIFO control: a full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        pop_s      = '0;
        full_s     = '0;
        accept_s   = '0;
        drop_s     = '0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        for (int c = 0; c < NCONSUMERS; c++) begin
            pop_s[c]    = (cnt_q[c] != '0) & resp_ready_i[c];
            full_s[c]   = (cnt_q[c] == DEPTH_C);
            accept_s[c] = push_s[c] & (~full_s[c] | pop_s[c]);
            drop_s[c]   = push_s[c] & full_s[c] & ~pop_s[c];
            if (accept_s[c]) begin
                wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
            end else begin
                wr_ptr_d[c] = wr_ptr_q[c];
            end
            if (pop_s[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
            end else begin
                rd_ptr_d[c] = rd_ptr_q[c];
            end
            case ({accept_s[c], pop_s[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CNT_W'(1);
                2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
                default: cnt_d[c] = cnt_q[c];
            endcase
            overflow_d[c] = overflow_q[c] | drop_s[c];
        end
        conflict_d = conflict_q | conflict_hit_s;
    end

    // FIFO storage, pointers, counts and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCONSUMERS; c++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCONSUMERS; c++) begin
                if (accept_s[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= push_data_s[c];
                end
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            conflict_q <= conflict_d;
        end
    end

    // Head word is forced to zero whenever the FIFO is empty.
    always_comb begin
        resp_valid_o = '0;
        resp_data_o  = '0;
        for (int c = 0; c < NCONSUMERS; c++) begin
            resp_valid_o[c] = (cnt_q[c] != '0);
            if (resp_valid_o[c]) begin
                resp_data_o[c] = mem_q[c][rd_ptr_q[c]];
            end else begin
                resp_data_o[c] = '0;
            end
        end
    end

    assign overflow_o = overflow_q;
    assign conflict_o = conflict_q;

endmodule

// File: tb/tb_rr_response_router.sv
// Bench for rr_response_router: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a queue-based response model.
module tb_rr_response_router;
    localparam int VW  = 8;
    localparam int NC  = 3;
    localparam int NB  = 1;
    localparam int NP  = 2;
    localparam int LAT = 3;
    localparam int FD  = 4;
    localparam int NK  = NB * NP;
    localparam int CW  = 2;

    logic                    clk   = 1'b0;
    logic                    reset = 1'b1;
    logic [NK-1:0]           gv    = '0;
    logic [NK-1:0]           gr    = '0;
    logic [NK-1:0][CW-1:0]   gc    = '0;
    logic [NK-1:0][VW-1:0]   rd    = '0;
    logic [NC-1:0]           rdy   = '0;
    logic [NC-1:0]           rv;
    logic [NC-1:0][VW-1:0]   rdat;
    logic [NC-1:0]           ovf;
    logic                    conf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rr_response_router #(
        .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB), .NPORTS(NP),
        .PLM_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset),
        .grant_valid_i(gv), .grant_is_read_i(gr), .grant_consumer_i(gc),
        .plm_rdata_i(rd),
        .resp_valid_o(rv), .resp_data_o(rdat), .resp_ready_i(rdy),
        .overflow_o(ovf), .conflict_o(conf)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: pending read grants with their due cycle, and one word queue per consumer.
    typedef struct { int due; int k; int c; } tag_t;
    typedef logic [VW-1:0] wq_t[$];
    tag_t           pend[$];
    wq_t            mq[NC];
    logic [NC-1:0]  m_ovf  = '0;
    logic           m_conf = 1'b0;

    task automatic model_step();
        bit             hit  [NC];
        logic [VW-1:0]  hw   [NC];
        bit             popc [NC];
        tag_t           t;
        if (reset) begin
            pend.delete();
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_ovf  = '0;
            m_conf = 1'b0;
            return;
        end
        for (int c = 0; c < NC; c++) begin
            hit[c]  = 1'b0;
            hw[c]   = '0;
            popc[c] = (mq[c].size() != 0) && rdy[c];
        end
        while (pend.size() != 0 && pend[0].due == cyc) begin
            t = pend.pop_front();
            if (hit[t.c]) m_conf = 1'b1;
            else begin
                hit[t.c] = 1'b1;
                hw[t.c]  = rd[t.k];
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (popc[c]) void'(mq[c].pop_front());
            if (hit[c]) begin
                if (mq[c].size() < FD) mq[c].push_back(hw[c]);
                else m_ovf[c] = 1'b1;
            end
        end
        for (int k = 0; k < NK; k++) begin
            if (gv[k] && gr[k] && int'(gc[k]) < NC) begin
                t.due = cyc + LAT;
                t.k   = k;
                t.c   = int'(gc[k]);
                pend.push_back(t);
            end
        end
    endtask

    // Compare process: advance the model on each rising edge and check just after it.
    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("resp_valid[%0d]", c), 32'(rv[c]), 32'(mq[c].size() != 0));
            if (mq[c].size() != 0)
                chk($sformatf("resp_data[%0d]", c), 32'(rdat[c]), 32'(mq[c][0]));
        end
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("conflict", 32'(conf), 32'(m_conf));
    end

    initial begin
        int pr;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_valid", 32'(rv), 32'h0);
        chk("reset_data", 32'(rdat), 32'h0);
        chk("reset_flags", {27'd0, ovf, conf}, 32'h0);

        // Single read for consumer 1.
        @(negedge clk);
        gv = 2'b01; gr = 2'b01; gc[0] = 2'd1; rd[0] = 8'h5A;
        @(negedge clk);
        gv = 2'b00;
        repeat (LAT - 1) @(negedge clk);
        chk("t1_not_yet", 32'(rv), 32'h0);
        @(negedge clk);
        chk("t1_valid", 32'(rv), 32'h2);
        chk("t1_data", 32'(rdat[1]), 32'h5A);
        rdy = 3'b111;
        @(negedge clk);
        chk("t1_drained", 32'(rv), 32'h0);

        // Write grant produces nothing.
        gv = 2'b01; gr = 2'b00; gc[0] = 2'd0;
        @(negedge clk);
        gv = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_no_resp", 32'(rv), 32'h0);
        end

        // Back-to-back reads 1..4 to consumer 0 with ready high.
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            if (j >= 4 && j <= 7) begin
                chk("t3_valid", 32'(rv[0]), 32'h1);
                chk("t3_data", 32'(rdat[0]), 32'(j - 3));
            end
            if (j == 8) chk("t3_end", 32'(rv), 32'h0);
            gv = (j < 4) ? 2'b01 : 2'b00; gr = 2'b01; gc[0] = 2'd0;
            rd[0] = (j >= LAT) ? 8'(j - LAT + 1) : 8'h00;
        end

        // Five reads into a stalled FIFO of depth 4.
        rdy = 3'b000;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            gv = (j < 5) ? 2'b01 : 2'b00; gr = 2'b01; gc[0] = 2'd0;
            rd[0] = (j >= LAT) ? 8'(10 + j - LAT) : 8'h00;
        end
        @(negedge clk);
        gv = 2'b00;
        chk("t4_valid", 32'(rv[0]), 32'h1);
        chk("t4_head", 32'(rdat[0]), 32'd10);
        chk("t4_overflow", 32'(ovf), 32'h1);
        rdy = 3'b001;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_valid", 32'(rv[0]), 32'h1);
            chk("t4_drain_data", 32'(rdat[0]), 32'(10 + i));
            @(negedge clk);
        end
        chk("t4_empty", 32'(rv[0]), 32'h0);

        // Two kernels hit consumer 1 in the same cycle.
        rdy = 3'b000;
        gv = 2'b11; gr = 2'b11; gc[0] = 2'd1; gc[1] = 2'd1; rd[0] = 8'hAA; rd[1] = 8'hBB;
        @(negedge clk);
        gv = 2'b00;
        repeat (LAT) @(negedge clk);
        chk("t5_valid", 32'(rv), 32'h2);
        chk("t5_data", 32'(rdat[1]), 32'hAA);
        chk("t5_conflict", 32'(conf), 32'h1);
        rdy = 3'b111;
        @(negedge clk);
        chk("t5_single", 32'(rv), 32'h0);

        // Reset with two words buffered and one tag in flight.
        rdy = 3'b000; rd[0] = 8'h33; gr = 2'b01; gc[0] = 2'd2;
        gv = 2'b01;
        @(negedge clk);
        @(negedge clk);
        gv = 2'b00;
        repeat (LAT) @(negedge clk);
        chk("t6_buffered", 32'(rv), 32'h4);
        gv = 2'b01;
        @(negedge clk);
        gv = 2'b00;
        reset = 1'b1;
        #1;
        chk("t6_reset_valid", 32'(rv), 32'h0);
        chk("t6_reset_data", 32'(rdat), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_quiet", 32'(rv), 32'h0);
        end
        chk("t6_flags", {27'd0, ovf, conf}, 32'h0);

        // Random traffic in two phases with different back-pressure.
        for (int ph = 0; ph < 2; ph++) begin
            pr = (ph == 0) ? 85 : 35;
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                for (int k = 0; k < NK; k++) begin
                    gv[k] = ($urandom_range(0, 99) < 50);
                    gr[k] = ($urandom_range(0, 3) != 0);
                    gc[k] = CW'($urandom_range(0, 3));
                    rd[k] = VW'($urandom);
                end
                for (int c = 0; c < NC; c++) rdy[c] = ($urandom_range(0, 99) < pr);
            end
            @(negedge clk);
            gv = '0;
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end

        gv = '0;
        rdy = '1;
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
